// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Word type, PC step, NOP and address helpers.
package pc_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_INC     = 32'd4;
  localparam word_t NOP_INSTR  = 32'h0000_0000;
  localparam word_t ALIGN_MASK = 32'hFFFF_FFFC;

  // Byte address reduced into a power-of-two memory window.
  function automatic word_t wrap_addr(
    input word_t addr,
    input word_t mask
  );
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_sel.sv
// Redirect priority, target alignment and
// address wrap for the fetch unit.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic  branch_taken_i,
  input  word_t branch_target_i,
  input  logic  jump_i,
  input  word_t jump_target_i,
  input  word_t pc_i,
  input  word_t fetch_pc_i,
  output logic  redirect_o,
  output logic  misalign_o,
  output word_t target_o,
  output word_t target_plus4_o,
  output word_t pc_plus4_o,
  output word_t fetch_pc_plus4_o
);

  localparam word_t WIN_MASK = word_t'(IMEM_BYTES - 1);

  word_t raw_target;

  // Branch is older than the jump, so it wins a tie.
  always_comb begin
    raw_target = jump_target_i;
    if (branch_taken_i) raw_target = branch_target_i;
  end

  assign redirect_o = branch_taken_i | jump_i;
  assign misalign_o = redirect_o & (raw_target[1:0] != 2'b00);

  assign target_o = wrap_addr(raw_target & ALIGN_MASK, WIN_MASK);
  assign target_plus4_o = wrap_addr(target_o + PC_INC, WIN_MASK);
  assign pc_plus4_o = wrap_addr(pc_i + PC_INC, WIN_MASK);
  assign fetch_pc_plus4_o = wrap_addr(fetch_pc_i + PC_INC, WIN_MASK);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC sequencing,
// redirects, stall hold and decode handoff.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        id_valid_o,
  output logic        misalign_err_o,
  output logic [31:0] fetch_count_o
);

  word_t pc_q, pc_d;
  word_t fetch_pc_q, fetch_pc_d;
  logic  fetch_valid_q, fetch_valid_d;
  logic  misalign_q, misalign_d;
  word_t count_q, count_d;

  logic  redirect;
  logic  misalign;
  word_t target;
  word_t target_plus4;
  word_t pc_plus4;
  word_t fetch_pc_plus4;

  pc_next_sel #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next_sel (
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .jump_i           (jump_i),
    .jump_target_i    (jump_target_i),
    .pc_i             (pc_q),
    .fetch_pc_i       (fetch_pc_q),
    .redirect_o       (redirect),
    .misalign_o       (misalign),
    .target_o         (target),
    .target_plus4_o   (target_plus4),
    .pc_plus4_o       (pc_plus4),
    .fetch_pc_plus4_o (fetch_pc_plus4)
  );

  // Address to memory; a stall re-reads the in-flight word.
  always_comb begin
    imem_addr_o = pc_q;
    if (redirect)     imem_addr_o = target;
    else if (stall_i) imem_addr_o = fetch_pc_q;
    imem_addr_o[1:0] = 2'b00;
  end

  assign id_instr_o    = imem_instr_i;
  assign id_pc_o       = fetch_pc_q;
  assign id_pc_plus4_o = fetch_pc_plus4;
  assign id_valid_o    = fetch_valid_q & ~redirect;

  // Next fetch state: redirect beats stall beats sequential.
  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    if (redirect) begin
      pc_d          = target_plus4;
      fetch_pc_d    = target;
      fetch_valid_d = 1'b1;
    end else if (!stall_i) begin
      pc_d          = pc_plus4;
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b1;
    end
  end

  // Sticky misalign flag and saturating accept counter.
  always_comb begin
    misalign_d = misalign_q | misalign;
    count_d    = count_q;
    if (id_valid_o && !stall_i && count_q != 32'hFFFF_FFFF)
      count_d = count_q + 32'd1;
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign misalign_err_o = misalign_q;
  assign fetch_count_o  = count_q;

endmodule
